// File: rtl/pipelined_cla_adder_pkg.sv
// Shared constants and helpers for the pipelined carry-look-ahead adder.
// The group width and the add/subtract mode encodings live here so the
// top level and the look-ahead group agree on them.
package pipelined_cla_adder_pkg;

    // Width of one carry-look-ahead group in bits
    localparam int CLA_GRP = 4;

    // Operation select carried on the sub input
    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } cla_mode_e;

    // Conditionally inverts one group of operand B for subtraction (b' = b ^ sub)
    function automatic logic [CLA_GRP-1:0] invert_if_sub(
        input logic [CLA_GRP-1:0] b,
        input logic               sub
    );
        return b ^ {CLA_GRP{sub}};
    endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand / result handshake bundle of the pipelined adder.
// The master side offers operands and consumes results; the slave side
// is the adder itself.
interface pipelined_cla_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf, zero
    );

endinterface

// File: rtl/pipelined_cla_adder_cla_group4.sv
// Combinational 4-bit carry-look-ahead group.
// b is expected already conditioned for subtraction (b' = b ^ sub).
// Produces the sum, the carry out, and the group propagate/generate used
// by the enclosing slice to ripple carries from group to group.
module cla_group4
    import pipelined_cla_adder_pkg::*;
(
    input  logic [CLA_GRP-1:0] a,
    input  logic [CLA_GRP-1:0] b,
    input  logic               ci,
    output logic [CLA_GRP-1:0] s,
    output logic               co,
    output logic               grp_p,
    output logic               grp_g
);

    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] x;
    logic [3:0] c;

    assign p = a | b;
    assign g = a & b;
    assign x = a ^ b;

    // Look-ahead carries into each bit of the group, all derived from ci
    always_comb begin
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    end

    // Group propagate/generate and carry out of the whole group
    always_comb begin
        grp_p = &p;
        grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        co    = grp_g | (grp_p & ci);
    end

    assign s = x ^ c;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-look-ahead adder/subtractor with valid/ready handshake.
// The operand is cut into STAGES slices; each pipeline stage adds one
// slice and registers the carry for the next one. Operand bits still to be
// added ride along in skew registers, finished sum bits ride along in
// de-skew registers, so every slice of a transaction leaves together.
// The whole pipe advances as one unit: a stalled output freezes every stage.
module pipelined_cla_adder
    import pipelined_cla_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
)
(
    input  logic                 clk,
    input  logic                 reset,
    pipelined_cla_adder_if.slave bus
);

    localparam int SAFE_STAGES = (STAGES > 0) ? STAGES : 1;
    localparam int SLICE       = WIDTH / SAFE_STAGES;
    localparam int GPS         = SLICE / CLA_GRP;
    localparam int NGRP        = WIDTH / CLA_GRP;
    localparam int LAST        = SAFE_STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH / CLA_GRP) begin : g_bad_stages
        $error("pipelined_cla_adder: STAGES must lie in 1..WIDTH/4");
    end else if (WIDTH % (CLA_GRP * STAGES) != 0) begin : g_bad_width
        $error("pipelined_cla_adder: WIDTH must be a multiple of 4*STAGES");
    end

    logic             adv;

    logic             src_vld [SAFE_STAGES];
    logic             src_sub [SAFE_STAGES];
    logic             src_cin [SAFE_STAGES];
    logic [WIDTH-1:0] src_a   [SAFE_STAGES];
    logic [WIDTH-1:0] src_b   [SAFE_STAGES];
    logic [WIDTH-1:0] src_sum [SAFE_STAGES];
    logic [WIDTH-1:0] nxt_sum [SAFE_STAGES];
    logic             slice_co[SAFE_STAGES];

    logic [CLA_GRP-1:0] grp_s [NGRP];
    logic               grp_ci[NGRP];
    logic               grp_p [NGRP];
    logic               grp_g [NGRP];
    logic               grp_co[NGRP];

    logic             vld_r [SAFE_STAGES];
    logic             sub_r [SAFE_STAGES];
    logic             cry_r [SAFE_STAGES];
    logic [WIDTH-1:0] a_r   [SAFE_STAGES];
    logic [WIDTH-1:0] b_r   [SAFE_STAGES];
    logic [WIDTH-1:0] sum_r [SAFE_STAGES];

    logic             ovf_r;
    logic             zero_r;
    logic             msb_cin;
    logic             ovf_nxt;
    logic             zero_nxt;

    // The pipe moves only when the output slot is empty or being taken
    assign adv          = ~vld_r[LAST] | bus.out_ready;
    assign bus.in_ready = adv;

    // Each stage reads from the handshake inputs (stage 0) or from the
    // registers written by the previous stage
    always_comb begin
        src_vld[0] = bus.in_valid;
        src_a[0]   = bus.a;
        src_b[0]   = bus.b;
        src_sub[0] = bus.sub;
        src_cin[0] = (bus.sub == MODE_SUB);
        src_sum[0] = '0;
        for (int k = 1; k < SAFE_STAGES; k++) begin
            src_vld[k] = vld_r[k-1];
            src_a[k]   = a_r[k-1];
            src_b[k]   = b_r[k-1];
            src_sub[k] = sub_r[k-1];
            src_cin[k] = cry_r[k-1];
            src_sum[k] = sum_r[k-1];
        end
    end

    // One look-ahead group per 4 bits; group gi belongs to slice gi/GPS and
    // therefore works on the transaction currently held by that stage
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp
        localparam int K = gi / GPS;

        logic [CLA_GRP-1:0] b_eff;

        assign b_eff = invert_if_sub(src_b[K][gi*CLA_GRP +: CLA_GRP], src_sub[K]);

        if ((gi % GPS) == 0) begin : g_first
            assign grp_ci[gi] = src_cin[K];
        end else begin : g_chain
            assign grp_ci[gi] = grp_g[gi-1] | (grp_p[gi-1] & grp_ci[gi-1]);
        end

        cla_group4 u_grp (
            .a     (src_a[K][gi*CLA_GRP +: CLA_GRP]),
            .b     (b_eff),
            .ci    (grp_ci[gi]),
            .s     (grp_s[gi]),
            .co    (grp_co[gi]),
            .grp_p (grp_p[gi]),
            .grp_g (grp_g[gi])
        );
    end

    // Merge each stage's fresh slice into the de-skewed sum and pick up
    // the carry leaving the slice's top group
    always_comb begin
        for (int k = 0; k < SAFE_STAGES; k++) begin
            nxt_sum[k] = src_sum[k];
            for (int j = 0; j < GPS; j++) begin
                nxt_sum[k][(k*GPS + j)*CLA_GRP +: CLA_GRP] = grp_s[k*GPS + j];
            end
            slice_co[k] = grp_co[k*GPS + GPS - 1];
        end
    end

    // Status flags of the final stage: the carry into the MSB is recovered
    // from the MSB sum bit and its two operand bits
    always_comb begin
        msb_cin  = nxt_sum[LAST][WIDTH-1] ^ src_a[LAST][WIDTH-1]
                 ^ src_b[LAST][WIDTH-1] ^ src_sub[LAST];
        ovf_nxt  = msb_cin ^ slice_co[LAST];
        zero_nxt = (nxt_sum[LAST] == '0);
    end

    // Stage valid bits: a bubble enters stage 0 when nothing is offered
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SAFE_STAGES; k++) begin
                vld_r[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < SAFE_STAGES; k++) begin
                vld_r[k] <= src_vld[k];
            end
        end
    end

    // Skew, carry and de-skew registers; only live transactions are loaded
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SAFE_STAGES; k++) begin
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                sum_r[k] <= '0;
                sub_r[k] <= 1'b0;
                cry_r[k] <= 1'b0;
            end
        end else if (adv) begin
            for (int k = 0; k < SAFE_STAGES; k++) begin
                if (src_vld[k]) begin
                    a_r[k]   <= src_a[k];
                    b_r[k]   <= src_b[k];
                    sum_r[k] <= nxt_sum[k];
                    sub_r[k] <= src_sub[k];
                    cry_r[k] <= slice_co[k];
                end
            end
        end
    end

    // Registered overflow and zero flags, aligned with the final sum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r  <= 1'b0;
            zero_r <= 1'b0;
        end else if (adv && src_vld[LAST]) begin
            ovf_r  <= ovf_nxt;
            zero_r <= zero_nxt;
        end
    end

    assign bus.out_valid = vld_r[LAST];
    assign bus.sum       = sum_r[LAST];
    assign bus.co        = cry_r[LAST];
    assign bus.ovf       = ovf_r;
    assign bus.zero      = zero_r;

endmodule
